// File: rtl/clock_pkg.sv
// Shared types, field widths and wrap helpers for the 24-hour clock datapath.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        return (h == MAX_HOUR) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
        return (m == MAX_MIN) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/time_set_controller_btn_repeat.sv
// Increment button front end: press detect plus hold-to-repeat event generation.
module btn_repeat #(
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 1
) (
    input  logic clk_1Hz,
    input  logic rst,
    input  logic btn_i,
    input  logic en_i,
    input  logic clr_i,
    output logic press_o,
    output logic event_o
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LD  = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] RATE_LD = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             prev_q;
    logic             suppress_q, suppress_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    assign press_o = btn_i & ~prev_q;

    // hold_q counts down to the next repeat; 0 means no repeat is armed.
    always_comb begin
        hold_d     = hold_q;
        event_o    = 1'b0;
        suppress_d = btn_i & (suppress_q | clr_i);
        if (clr_i || !en_i || !btn_i || suppress_q) begin
            hold_d = '0;
        end else if (press_o) begin
            event_o = 1'b1;
            hold_d  = DLY_LD;
        end else if (hold_q == CNT_ONE) begin
            event_o = 1'b1;
            hold_d  = RATE_LD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst) begin
            prev_q     <= 1'b1;
            suppress_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            prev_q     <= btn_i;
            suppress_q <= suppress_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Mode/edit sequencer: freezes the time counters, edits hours then minutes, commits via one-cycle load.
//  state   | meaning
//  RUN     | counters running, buttons only watched for a mode press
//  SET_HR  | counters frozen, inc steps edit_hr
//  SET_MIN | counters frozen, inc steps edit_min; mode press commits
module time_set_controller
    import clock_pkg::*;
#(
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 1,
    parameter int TIMEOUT     = 30
) (
    input  logic              clk_1Hz,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              run_en,
    output logic              load,
    output logic [HOUR_W-1:0] load_hours,
    output logic [MIN_W-1:0]  load_minutes,
    output logic [SEC_W-1:0]  load_seconds,
    output logic [1:0]        mode_state,
    output logic              blink
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    mode_e             state_q, state_d;
    logic              run_en_q, run_en_d;
    logic              load_q, load_d;
    logic              blink_q, blink_d;
    logic [HOUR_W-1:0] edit_hr_q, edit_hr_d;
    logic [MIN_W-1:0]  edit_min_q, edit_min_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              mode_prev_q;

    logic in_set, mode_press, inc_press, inc_evt, inc_act, timeout, clr;

    assign in_set     = (state_q != RUN);
    assign mode_press = btn_mode & ~mode_prev_q;
    assign inc_act    = inc_press | inc_evt;
    assign timeout    = in_set & ~mode_press & ~inc_act & (idle_q == IDLE_LAST);
    assign clr        = mode_press | timeout;

    btn_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
    ) u_inc (
        .clk_1Hz(clk_1Hz),
        .rst    (rst),
        .btn_i  (btn_inc),
        .en_i   (in_set),
        .clr_i  (clr),
        .press_o(inc_press),
        .event_o(inc_evt)
    );

    always_comb begin
        state_d    = state_q;
        run_en_d   = run_en_q;
        load_d     = 1'b0;
        blink_d    = in_set ? ~blink_q : 1'b0;
        edit_hr_d  = edit_hr_q;
        edit_min_d = edit_min_q;
        idle_d     = (in_set && !inc_act) ? idle_q + 1'b1 : '0;
        unique case (state_q)
            RUN: begin
                if (mode_press) begin
                    state_d    = SET_HR;
                    run_en_d   = 1'b0;
                    blink_d    = 1'b1;
                    edit_hr_d  = cur_hours;
                    edit_min_d = cur_minutes;
                end
            end
            SET_HR: begin
                if (mode_press) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                    idle_d  = '0;
                end else if (timeout) begin
                    state_d  = RUN;
                    run_en_d = 1'b1;
                    blink_d  = 1'b0;
                end else if (inc_evt) begin
                    edit_hr_d = next_hour(edit_hr_q);
                end
            end
            SET_MIN: begin
                if (mode_press) begin
                    state_d  = RUN;
                    run_en_d = 1'b1;
                    load_d   = 1'b1;
                    blink_d  = 1'b0;
                end else if (timeout) begin
                    state_d  = RUN;
                    run_en_d = 1'b1;
                    blink_d  = 1'b0;
                end else if (inc_evt) begin
                    edit_min_d = next_min(edit_min_q);
                end
            end
            default: begin
                state_d  = RUN;
                run_en_d = 1'b1;
                blink_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst) begin
            state_q     <= RUN;
            run_en_q    <= 1'b1;
            load_q      <= 1'b0;
            blink_q     <= 1'b0;
            edit_hr_q   <= '0;
            edit_min_q  <= '0;
            idle_q      <= '0;
            mode_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            run_en_q    <= run_en_d;
            load_q      <= load_d;
            blink_q     <= blink_d;
            edit_hr_q   <= edit_hr_d;
            edit_min_q  <= edit_min_d;
            idle_q      <= idle_d;
            mode_prev_q <= btn_mode;
        end
    end

    assign run_en       = run_en_q;
    assign load         = load_q;
    assign load_hours   = edit_hr_q;
    assign load_minutes = edit_min_q;
    assign load_seconds = '0;
    assign mode_state   = state_q;
    assign blink        = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Table-driven bench with an expected-value queue for time_set_controller.
module tb_time_set_controller;

    localparam int TMO = 30;

    typedef struct packed {
        logic       m;
        logic       i;
        logic [4:0] h;
        logic [5:0] mi;
        logic [1:0] st;
        logic       run;
        logic       ld;
        logic [4:0] lh;
        logic [5:0] lm;
        logic       bl;
    } vec_t;

    logic       clk_1Hz = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_inc = 1'b1;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic       run_en, load, blink;
    logic [4:0] load_hours;
    logic [5:0] load_minutes, load_seconds;
    logic [1:0] mode_state;

    int checks = 0;
    int errors = 0;
    int ntbl = 0;
    vec_t tbl[64];
    vec_t exp_q[$];

    time_set_controller #(.REPEAT_DLY(4), .REPEAT_RATE(1), .TIMEOUT(TMO)) dut (
        .clk_1Hz     (clk_1Hz),
        .rst         (rst),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .cur_hours   (cur_hours),
        .cur_minutes (cur_minutes),
        .run_en      (run_en),
        .load        (load),
        .load_hours  (load_hours),
        .load_minutes(load_minutes),
        .load_seconds(load_seconds),
        .mode_state  (mode_state),
        .blink       (blink)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic vec_t mk(int m, int i, int h, int mi, int st, int run, int ld,
                                int lh, int lm, int bl);
        vec_t v;
        v.m = m[0]; v.i = i[0]; v.h = h[4:0]; v.mi = mi[5:0];
        v.st = st[1:0]; v.run = run[0]; v.ld = ld[0];
        v.lh = lh[4:0]; v.lm = lm[5:0]; v.bl = bl[0];
        return v;
    endfunction

    task automatic add(int m, int i, int h, int mi, int st, int run, int ld, int lh, int lm, int bl);
        tbl[ntbl] = mk(m, i, h, mi, st, run, ld, lh, lm, bl);
        ntbl++;
    endtask

    task automatic chk(input string nm, input int step_no, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, step_no, act, exp);
        end
    endtask

    // Drive one edge's inputs, queue the expected post-edge outputs, compare after the edge.
    task automatic step(input vec_t v, input logic r, input int step_no);
        vec_t e;
        btn_mode = v.m; btn_inc = v.i; cur_hours = v.h; cur_minutes = v.mi; rst = r;
        exp_q.push_back(v);
        @(posedge clk_1Hz);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: queue empty", step_no);
        end else begin
            e = exp_q.pop_front();
            chk("mode_state",   step_no, int'(mode_state),   int'(e.st));
            chk("run_en",       step_no, int'(run_en),       int'(e.run));
            chk("load",         step_no, int'(load),         int'(e.ld));
            chk("load_hours",   step_no, int'(load_hours),   int'(e.lh));
            chk("load_minutes", step_no, int'(load_minutes), int'(e.lm));
            chk("blink",        step_no, int'(blink),        int'(e.bl));
            chk("load_seconds", step_no, int'(load_seconds), 0);
        end
    endtask

    initial begin
        // m  i  h   mi  st run ld lh  lm  bl
        add(1, 1, 23, 59, 0, 1, 0,  0,  0, 0);  // held through reset: no press
        add(0, 0, 23, 59, 0, 1, 0,  0,  0, 0);
        add(1, 0, 23, 59, 1, 0, 0, 23, 59, 1);  // enter SET_HR, capture
        add(0, 0, 23, 59, 1, 0, 0, 23, 59, 0);
        add(0, 1, 23, 59, 1, 0, 0,  0, 59, 1);  // hour wrap 23 -> 0
        add(0, 0, 23, 59, 1, 0, 0,  0, 59, 0);
        add(1, 0, 23, 59, 2, 0, 0,  0, 59, 1);  // SET_MIN
        add(0, 1, 23, 59, 2, 0, 0,  0,  0, 0);  // minute wrap 59 -> 0
        add(0, 0, 23, 59, 2, 0, 0,  0,  0, 1);
        add(0, 1, 23, 59, 2, 0, 0,  0,  1, 0);
        add(0, 0, 23, 59, 2, 0, 0,  0,  1, 1);
        add(0, 1, 23, 59, 2, 0, 0,  0,  2, 0);
        add(0, 0, 23, 59, 2, 0, 0,  0,  2, 1);
        add(1, 0, 23, 59, 0, 1, 1,  0,  2, 0);  // commit
        add(0, 0, 23, 59, 0, 1, 0,  0,  2, 0);  // load gone
        add(1, 0,  5, 58, 1, 0, 0,  5, 58, 1);
        add(0, 0,  5, 58, 1, 0, 0,  5, 58, 0);
        add(1, 0,  5, 58, 2, 0, 0,  5, 58, 1);
        add(0, 1,  5, 58, 2, 0, 0,  5, 59, 0);  // hold: events at 0,4,5..9
        add(0, 1,  5, 58, 2, 0, 0,  5, 59, 1);
        add(0, 1,  5, 58, 2, 0, 0,  5, 59, 0);
        add(0, 1,  5, 58, 2, 0, 0,  5, 59, 1);
        add(0, 1,  5, 58, 2, 0, 0,  5,  0, 0);
        add(0, 1,  5, 58, 2, 0, 0,  5,  1, 1);
        add(0, 1,  5, 58, 2, 0, 0,  5,  2, 0);
        add(0, 1,  5, 58, 2, 0, 0,  5,  3, 1);
        add(0, 1,  5, 58, 2, 0, 0,  5,  4, 0);
        add(0, 1,  5, 58, 2, 0, 0,  5,  5, 1);
        add(0, 0,  5, 58, 2, 0, 0,  5,  5, 0);
        add(1, 0,  5, 58, 0, 1, 1,  5,  5, 0);
        add(0, 0,  5, 58, 0, 1, 0,  5,  5, 0);
        add(1, 0, 10, 20, 1, 0, 0, 10, 20, 1);
        add(0, 0, 10, 20, 1, 0, 0, 10, 20, 0);
        add(1, 1, 10, 20, 2, 0, 0, 10, 20, 1);  // mode wins over inc
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 0);  // held: repeat suppressed
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 1);
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 0);
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 1);
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 0);
        add(0, 1, 10, 20, 2, 0, 0, 10, 20, 1);
        add(0, 0, 10, 20, 2, 0, 0, 10, 20, 0);
        add(0, 1, 10, 20, 2, 0, 0, 10, 21, 1);  // fresh press works again
        add(0, 0, 10, 20, 2, 0, 0, 10, 21, 0);
        add(1, 0, 10, 20, 0, 1, 1, 10, 21, 0);
        add(0, 0, 10, 20, 0, 1, 0, 10, 21, 0);
        add(0, 1, 10, 20, 0, 1, 0, 10, 21, 0);  // RUN ignores inc
        add(0, 0, 10, 20, 0, 1, 0, 10, 21, 0);

        // Reset with both buttons held.
        step(mk(1, 1, 23, 59, 0, 1, 0, 0, 0, 0), 1'b0, -2);
        step(mk(1, 1, 23, 59, 0, 1, 0, 0, 0, 0), 1'b0, -1);

        for (int k = 0; k < ntbl; k++) step(tbl[k], 1'b1, k);

        // Timeout from SET_HR: no load, run_en restored after TMO idle cycles.
        step(mk(1, 0, 7, 33, 1, 0, 0, 7, 33, 1), 1'b1, 100);
        for (int j = 1; j <= TMO; j++) begin
            if (j == TMO) step(mk(0, 0, 7, 33, 0, 1, 0, 7, 33, 0), 1'b1, 100 + j);
            else          step(mk(0, 0, 7, 33, 1, 0, 0, 7, 33, (j % 2 == 0) ? 1 : 0), 1'b1, 100 + j);
        end
        step(mk(0, 0, 7, 33, 0, 1, 0, 7, 33, 0), 1'b1, 200);

        // Reset mid-SET_MIN.
        step(mk(1, 0, 12, 40, 1, 0, 0, 12, 40, 1), 1'b1, 300);
        step(mk(0, 0, 12, 40, 1, 0, 0, 12, 40, 0), 1'b1, 301);
        step(mk(1, 0, 12, 40, 2, 0, 0, 12, 40, 1), 1'b1, 302);
        step(mk(0, 1, 12, 40, 2, 0, 0, 12, 41, 0), 1'b1, 303);
        step(mk(0, 0, 12, 40, 0, 1, 0,  0,  0, 0), 1'b0, 304);
        step(mk(0, 0, 12, 40, 0, 1, 0,  0,  0, 0), 1'b1, 305);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
